// File: rtl/sap_microsequencer_if.sv
// Control bus between the SAP-1 microsequencer and its datapath.
// The sequencer (master) consumes the IR opcode, the zero flag and the
// resume request, and drives every datapath strobe plus status.
interface sap_microsequencer_if #(
  parameter int OPW = 4
);

  // Datapath -> sequencer
  logic [OPW-1:0] opcode;
  logic           z_flag;
  logic           resume;

  // Sequencer -> datapath strobes (active-high)
  logic pc_out;
  logic pc_inc;
  logic pc_load;
  logic mar_load;
  logic ram_rd;
  logic ram_wr;
  logic ir_load;
  logic ir_out;
  logic a_load;
  logic a_out;
  logic b_load;
  logic alu_sub;
  logic alu_out;
  logic out_load;

  // Sequencer status
  logic       halted;
  logic       last_t;
  logic [2:0] tstate;

  modport master (
    input  opcode, z_flag, resume,
    output pc_out, pc_inc, pc_load, mar_load, ram_rd, ram_wr, ir_load,
           ir_out, a_load, a_out, b_load, alu_sub, alu_out, out_load,
           halted, last_t, tstate
  );

  modport slave (
    output opcode, z_flag, resume,
    input  pc_out, pc_inc, pc_load, mar_load, ram_rd, ram_wr, ir_load,
           ir_out, a_load, a_out, b_load, alu_sub, alu_out, out_load,
           halted, last_t, tstate
  );

endinterface

// File: rtl/sap_microsequencer.sv
// SAP-1 style ring-counter microsequencer.
// The T-state register advances on the falling clock edge so that the
// strobes it decodes are stable around the datapath's rising edge. All
// outputs are decoded combinationally from the T-state, the opcode and
// the zero flag. Fetch is T1..T3; execute occupies T4 up to T6 depending
// on the instruction. With FIXED_RING set, short instructions idle with
// no strobes until T6 so every instruction takes six states.
module sap_microsequencer #(
  parameter int             OPW        = 4,
  parameter logic [OPW-1:0] OP_LDA     = OPW'(0),
  parameter logic [OPW-1:0] OP_ADD     = OPW'(1),
  parameter logic [OPW-1:0] OP_SUB     = OPW'(2),
  parameter logic [OPW-1:0] OP_STA     = OPW'(3),
  parameter logic [OPW-1:0] OP_JMP     = OPW'(4),
  parameter logic [OPW-1:0] OP_JZ      = OPW'(5),
  parameter logic [OPW-1:0] OP_OUT     = OPW'(14),
  parameter logic [OPW-1:0] OP_HLT     = OPW'(15),
  parameter bit             FIXED_RING = 1'b0
) (
  input  logic                  clock,
  input  logic                  reset,
  sap_microsequencer_if.master  bus
);

  // State codes double as the tstate output value; code 0 is illegal.
  typedef enum logic [2:0] {
    ST_ILL  = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_T3   = 3'd3,
    ST_T4   = 3'd4,
    ST_T5   = 3'd5,
    ST_T6   = 3'd6,
    ST_HALT = 3'd7
  } state_e;

  state_e     state_q;
  state_e     state_d;
  logic [2:0] state_code_s;
  logic [2:0] exec_last_s;   // T-state number that ends this opcode's execute phase
  logic       exec_done_s;   // current state is that final execute state

  logic pc_out_s;
  logic pc_inc_s;
  logic pc_load_s;
  logic mar_load_s;
  logic ram_rd_s;
  logic ram_wr_s;
  logic ir_load_s;
  logic ir_out_s;
  logic a_load_s;
  logic a_out_s;
  logic b_load_s;
  logic alu_sub_s;
  logic alu_out_s;
  logic out_load_s;
  logic halted_s;
  logic last_t_s;

  assign state_code_s = state_q;

  // Length of the execute phase for the opcode held in the IR.
  always_comb begin
    exec_last_s = 3'd4;
    case (bus.opcode)
      OP_LDA:  exec_last_s = 3'd5;
      OP_STA:  exec_last_s = 3'd5;
      OP_ADD:  exec_last_s = 3'd6;
      OP_SUB:  exec_last_s = 3'd6;
      default: exec_last_s = 3'd4;   // JMP, JZ, OUT and undefined opcodes (NOP)
    endcase
  end

  assign exec_done_s = (state_code_s >= 3'd4) && (state_code_s <= 3'd6) &&
                       (state_code_s == exec_last_s);

  // Next T-state: fetch ring, opcode-dependent execute length, HALT hold.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_T1: state_d = ST_T2;
      ST_T2: state_d = ST_T3;
      ST_T3: begin
        if (bus.opcode == OP_HLT) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_T4;
        end
      end
      ST_T4: begin
        if (exec_done_s && !FIXED_RING) begin
          state_d = ST_T1;
        end else begin
          state_d = ST_T5;
        end
      end
      ST_T5: begin
        if (exec_done_s && !FIXED_RING) begin
          state_d = ST_T1;
        end else begin
          state_d = ST_T6;
        end
      end
      ST_T6: state_d = ST_T1;
      ST_HALT: begin
        if (bus.resume) begin
          state_d = ST_T1;
        end else begin
          state_d = ST_HALT;
        end
      end
      default: state_d = ST_T1;      // illegal code 0 recovers to T1
    endcase
  end

  // T-state register: falling-edge update, async active-low reset to T1.
  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_T1;
    end else begin
      state_q <= state_d;
    end
  end

  // Strobe decode; anything not named for a state stays low.
  always_comb begin
    pc_out_s   = 1'b0;
    pc_inc_s   = 1'b0;
    pc_load_s  = 1'b0;
    mar_load_s = 1'b0;
    ram_rd_s   = 1'b0;
    ram_wr_s   = 1'b0;
    ir_load_s  = 1'b0;
    ir_out_s   = 1'b0;
    a_load_s   = 1'b0;
    a_out_s    = 1'b0;
    b_load_s   = 1'b0;
    alu_sub_s  = 1'b0;
    alu_out_s  = 1'b0;
    out_load_s = 1'b0;
    halted_s   = 1'b0;
    case (state_q)
      ST_T1: begin
        pc_out_s   = 1'b1;
        mar_load_s = 1'b1;
      end
      ST_T2: begin
        pc_inc_s = 1'b1;
      end
      ST_T3: begin
        ram_rd_s  = 1'b1;
        ir_load_s = 1'b1;
      end
      ST_T4: begin
        case (bus.opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            ir_out_s   = 1'b1;
            mar_load_s = 1'b1;
          end
          OP_JMP: begin
            ir_out_s  = 1'b1;
            pc_load_s = 1'b1;
          end
          OP_JZ: begin
            if (bus.z_flag) begin
              ir_out_s  = 1'b1;
              pc_load_s = 1'b1;
            end else begin
              ir_out_s  = 1'b0;
              pc_load_s = 1'b0;
            end
          end
          OP_OUT: begin
            a_out_s    = 1'b1;
            out_load_s = 1'b1;
          end
          default: begin
            ir_out_s = 1'b0;         // NOP: no strobes
          end
        endcase
      end
      ST_T5: begin
        case (bus.opcode)
          OP_LDA: begin
            ram_rd_s = 1'b1;
            a_load_s = 1'b1;
          end
          OP_ADD: begin
            ram_rd_s = 1'b1;
            b_load_s = 1'b1;
          end
          OP_SUB: begin
            ram_rd_s  = 1'b1;
            b_load_s  = 1'b1;
            alu_sub_s = 1'b1;
          end
          OP_STA: begin
            a_out_s  = 1'b1;
            ram_wr_s = 1'b1;
          end
          default: begin
            ram_rd_s = 1'b0;         // idle fill state in fixed-ring mode
          end
        endcase
      end
      ST_T6: begin
        case (bus.opcode)
          OP_ADD: begin
            alu_out_s = 1'b1;
            a_load_s  = 1'b1;
          end
          OP_SUB: begin
            alu_out_s = 1'b1;
            a_load_s  = 1'b1;
            alu_sub_s = 1'b1;
          end
          default: begin
            alu_out_s = 1'b0;        // idle fill state in fixed-ring mode
          end
        endcase
      end
      ST_HALT: begin
        halted_s = 1'b1;
      end
      default: begin
        halted_s = 1'b0;             // illegal code: quiet until recovery
      end
    endcase
  end

  // Final-state flag: T6 only in fixed-ring mode, else the last execute state.
  always_comb begin
    if (FIXED_RING) begin
      last_t_s = (state_q == ST_T6);
    end else begin
      last_t_s = exec_done_s;
    end
  end

  assign bus.pc_out   = pc_out_s;
  assign bus.pc_inc   = pc_inc_s;
  assign bus.pc_load  = pc_load_s;
  assign bus.mar_load = mar_load_s;
  assign bus.ram_rd   = ram_rd_s;
  assign bus.ram_wr   = ram_wr_s;
  assign bus.ir_load  = ir_load_s;
  assign bus.ir_out   = ir_out_s;
  assign bus.a_load   = a_load_s;
  assign bus.a_out    = a_out_s;
  assign bus.b_load   = b_load_s;
  assign bus.alu_sub  = alu_sub_s;
  assign bus.alu_out  = alu_out_s;
  assign bus.out_load = out_load_s;
  assign bus.halted   = halted_s;
  assign bus.last_t   = last_t_s;
  assign bus.tstate   = state_code_s;

endmodule

// File: tb/tb_sap_microsequencer.sv
// Directed bench for sap_microsequencer: a vector table for the
// variable-length sequencer plus hand sequences for HALT, reset and
// fixed-ring behaviour. Inputs change and outputs are checked in the
// high clock phase, away from the falling edge that moves the state.
module tb_sap_microsequencer;

  localparam logic [13:0] PCO  = 14'h2000;
  localparam logic [13:0] PCI  = 14'h1000;
  localparam logic [13:0] PCL  = 14'h0800;
  localparam logic [13:0] MARL = 14'h0400;
  localparam logic [13:0] RRD  = 14'h0200;
  localparam logic [13:0] RWR  = 14'h0100;
  localparam logic [13:0] IRL  = 14'h0080;
  localparam logic [13:0] IRO  = 14'h0040;
  localparam logic [13:0] AL   = 14'h0020;
  localparam logic [13:0] AO   = 14'h0010;
  localparam logic [13:0] BL   = 14'h0008;
  localparam logic [13:0] ASUB = 14'h0004;
  localparam logic [13:0] ALUO = 14'h0002;
  localparam logic [13:0] OUTL = 14'h0001;
  localparam logic [13:0] NONE = 14'h0000;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_fail;

  sap_microsequencer_if #(.OPW(4)) bus0 ();
  sap_microsequencer_if #(.OPW(4)) bus1 ();

  sap_microsequencer #(.OPW(4), .FIXED_RING(1'b0)) u_dut0 (
    .clock (clock),
    .reset (reset),
    .bus   (bus0)
  );

  sap_microsequencer #(.OPW(4), .FIXED_RING(1'b1)) u_dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (bus1)
  );

  logic [13:0] strb0;
  logic [13:0] strb1;
  assign strb0 = {bus0.pc_out, bus0.pc_inc, bus0.pc_load, bus0.mar_load, bus0.ram_rd,
                  bus0.ram_wr, bus0.ir_load, bus0.ir_out, bus0.a_load, bus0.a_out,
                  bus0.b_load, bus0.alu_sub, bus0.alu_out, bus0.out_load};
  assign strb1 = {bus1.pc_out, bus1.pc_inc, bus1.pc_load, bus1.mar_load, bus1.ram_rd,
                  bus1.ram_wr, bus1.ir_load, bus1.ir_out, bus1.a_load, bus1.a_out,
                  bus1.b_load, bus1.alu_sub, bus1.alu_out, bus1.out_load};

  typedef struct {
    logic [3:0]  op;
    logic        z;
    logic        res;
    logic [2:0]  ts;
    logic [13:0] strb;
    logic        halted;
    logic        last;
  } vec_t;

  vec_t vecs[$];

  initial clock = 1'b1;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [3:0] op, input logic z, input logic res,
                         input logic [2:0] ts, input logic [13:0] strb,
                         input logic halted, input logic last);
    vec_t v;
    v.op = op; v.z = z; v.res = res; v.ts = ts;
    v.strb = strb; v.halted = halted; v.last = last;
    vecs.push_back(v);
  endtask

  task automatic add_fetch(input logic [3:0] op, input logic z);
    add_vec(op, z, 1'b0, 3'd1, PCO | MARL, 1'b0, 1'b0);
    add_vec(op, z, 1'b0, 3'd2, PCI,        1'b0, 1'b0);
    add_vec(op, z, 1'b0, 3'd3, RRD | IRL,  1'b0, 1'b0);
  endtask

  // Advance one falling edge and park in the middle of the high phase.
  task automatic step();
    @(negedge clock);
    @(posedge clock);
    #1;
  endtask

  task automatic excl0();
    chk("excl_rd_wr",  {31'd0, bus0.ram_rd & bus0.ram_wr},  32'd0);
    chk("excl_inc_ld", {31'd0, bus0.pc_inc & bus0.pc_load}, 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_out0", {13'd0, bus0.tstate, strb0, bus0.halted, bus0.last_t},
                    {13'd0, 3'd1, PCO | MARL, 1'b0, 1'b0});
    chk("rst_out1", {13'd0, bus1.tstate, strb1, bus1.halted, bus1.last_t},
                    {13'd0, 3'd1, PCO | MARL, 1'b0, 1'b0});
    @(negedge clock);
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    logic [13:0] ring_strb [6];
    int          cnt;
    int          exp_len;
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b0;
    bus0.opcode = 4'd0; bus0.z_flag = 1'b0; bus0.resume = 1'b0;
    bus1.opcode = 4'd0; bus1.z_flag = 1'b0; bus1.resume = 1'b0;

    // ---------------- vector table (FIXED_RING = 0) ----------------
    add_fetch(4'd1, 1'b0);                                  // ADD
    add_vec(4'd1, 1'b0, 1'b0, 3'd4, IRO | MARL,        1'b0, 1'b0);
    add_vec(4'd1, 1'b0, 1'b0, 3'd5, RRD | BL,          1'b0, 1'b0);
    add_vec(4'd1, 1'b0, 1'b0, 3'd6, ALUO | AL,         1'b0, 1'b1);
    add_fetch(4'd2, 1'b0);                                  // SUB
    add_vec(4'd2, 1'b0, 1'b0, 3'd4, IRO | MARL,        1'b0, 1'b0);
    add_vec(4'd2, 1'b0, 1'b0, 3'd5, RRD | BL | ASUB,   1'b0, 1'b0);
    add_vec(4'd2, 1'b0, 1'b0, 3'd6, ALUO | AL | ASUB,  1'b0, 1'b1);
    add_fetch(4'd0, 1'b0);                                  // LDA
    add_vec(4'd0, 1'b0, 1'b0, 3'd4, IRO | MARL,        1'b0, 1'b0);
    add_vec(4'd0, 1'b0, 1'b0, 3'd5, RRD | AL,          1'b0, 1'b1);
    add_fetch(4'd3, 1'b0);                                  // STA
    add_vec(4'd3, 1'b0, 1'b0, 3'd4, IRO | MARL,        1'b0, 1'b0);
    add_vec(4'd3, 1'b0, 1'b0, 3'd5, AO | RWR,          1'b0, 1'b1);
    add_fetch(4'd4, 1'b0);                                  // JMP
    add_vec(4'd4, 1'b0, 1'b0, 3'd4, IRO | PCL,         1'b0, 1'b1);
    add_fetch(4'd5, 1'b1);                                  // JZ taken
    add_vec(4'd5, 1'b1, 1'b0, 3'd4, IRO | PCL,         1'b0, 1'b1);
    add_fetch(4'd5, 1'b0);                                  // JZ not taken
    add_vec(4'd5, 1'b0, 1'b0, 3'd4, NONE,              1'b0, 1'b1);
    add_fetch(4'd14, 1'b0);                                 // OUT
    add_vec(4'd14, 1'b0, 1'b0, 3'd4, AO | OUTL,        1'b0, 1'b1);
    add_fetch(4'd7, 1'b0);                                  // undefined -> NOP
    add_vec(4'd7, 1'b0, 1'b0, 3'd4, NONE,              1'b0, 1'b1);
    add_fetch(4'd15, 1'b0);                                 // HLT
    add_vec(4'd15, 1'b0, 1'b0, 3'd7, NONE,             1'b1, 1'b0);
    add_vec(4'd15, 1'b0, 1'b0, 3'd7, NONE,             1'b1, 1'b0);
    add_vec(4'd15, 1'b0, 1'b1, 3'd7, NONE,             1'b1, 1'b0);
    add_fetch(4'd0, 1'b0);                                  // resumed: LDA
    add_vec(4'd0, 1'b0, 1'b0, 3'd4, IRO | MARL,        1'b0, 1'b0);
    add_vec(4'd0, 1'b0, 1'b0, 3'd5, RRD | AL,          1'b0, 1'b1);
    add_vec(4'd0, 1'b0, 1'b0, 3'd1, PCO | MARL,        1'b0, 1'b0);

    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      bus0.opcode = vecs[i].op;
      bus0.z_flag = vecs[i].z;
      bus0.resume = vecs[i].res;
      #1;
      chk($sformatf("vec%0d", i),
          {13'd0, bus0.tstate, strb0, bus0.halted, bus0.last_t},
          {13'd0, vecs[i].ts, vecs[i].strb, vecs[i].halted, vecs[i].last});
      excl0();
      step();
    end
    bus0.resume = 1'b0;

    // ---------------- all opcodes: length, return to T1, exclusion ----------------
    do_reset();
    for (int op = 0; op < 16; op++) begin
      bus0.opcode = op[3:0];
      bus0.z_flag = op[0];
      if (op == 1 || op == 2)      exp_len = 6;
      else if (op == 0 || op == 3) exp_len = 5;
      else                         exp_len = 4;
      if (op == 15) begin
        repeat (3) begin
          excl0();
          step();
        end
        chk("sweep_hlt_ts", {29'd0, bus0.tstate}, 32'd7);
        bus0.resume = 1'b1;
        step();
        bus0.resume = 1'b0;
        chk("sweep_hlt_resume", {29'd0, bus0.tstate}, 32'd1);
      end else begin
        cnt = 1;
        excl0();
        while (!bus0.last_t && cnt < 8) begin
          step();
          cnt++;
          excl0();
        end
        chk($sformatf("sweep_len_op%0d", op), cnt, exp_len);
        step();
        chk($sformatf("sweep_next_op%0d", op), {29'd0, bus0.tstate}, 32'd1);
      end
    end

    // ---------------- HLT held for 10 clocks, then resume ----------------
    do_reset();
    bus0.opcode = 4'd15;
    repeat (3) step();
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("halt_hold%0d", k), {29'd0, bus0.tstate, bus0.halted},
          {29'd0, 3'd7, 1'b1});
      step();
    end
    bus0.resume = 1'b1;
    step();
    bus0.resume = 1'b0;
    chk("halt_resume", {28'd0, bus0.tstate, bus0.halted}, {28'd0, 3'd1, 1'b0});
    // back into HALT, then reset between edges
    repeat (3) step();
    chk("halt_again", {29'd0, bus0.tstate}, 32'd7);
    #2;
    reset = 1'b0;
    #1;
    chk("halt_rst", {28'd0, bus0.tstate, bus0.halted}, {28'd0, 3'd1, 1'b0});
    @(posedge clock);
    #1;
    reset = 1'b1;

    // ---------------- reset in T5 of SUB ----------------
    do_reset();
    bus0.opcode = 4'd2;
    repeat (4) step();
    chk("sub_t5", {28'd0, bus0.tstate, bus0.alu_sub}, {28'd0, 3'd5, 1'b1});
    #2;
    reset = 1'b0;
    #1;
    chk("sub_rst", {13'd0, bus0.tstate, strb0, bus0.halted, bus0.last_t},
                   {13'd0, 3'd1, PCO | MARL, 1'b0, 1'b0});
    @(negedge clock);
    #1;
    chk("rst_hold_edge", {29'd0, bus0.tstate}, 32'd1);
    @(posedge clock);
    #1;
    reset = 1'b1;
    step();
    chk("first_edge_t2", {29'd0, bus0.tstate}, 32'd2);

    // ---------------- FIXED_RING = 1: LDA then JMP ----------------
    for (int pass = 0; pass < 2; pass++) begin
      ring_strb[0] = PCO | MARL;
      ring_strb[1] = PCI;
      ring_strb[2] = RRD | IRL;
      ring_strb[3] = (pass == 0) ? (IRO | MARL) : (IRO | PCL);
      ring_strb[4] = (pass == 0) ? (RRD | AL) : NONE;
      ring_strb[5] = NONE;
      bus1.opcode = (pass == 0) ? 4'd0 : 4'd4;
      do_reset();
      for (int t = 0; t < 6; t++) begin
        chk($sformatf("ring%0d_t%0d", pass, t + 1),
            {13'd0, bus1.tstate, strb1, bus1.halted, bus1.last_t},
            {13'd0, 3'(t + 1), ring_strb[t], 1'b0, (t == 5) ? 1'b1 : 1'b0});
        step();
      end
      chk($sformatf("ring%0d_wrap", pass), {29'd0, bus1.tstate}, 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sap_microsequencer.md
SAP_MICROSEQUENCER -- requirements
Module: sap_microsequencer

Interface
REQ-001 SHALL have parameter OPW, default 4, meaning opcode width in bits (minimum 4).
REQ-002 SHALL have parameters OP_LDA=0, OP_ADD=1, OP_SUB=2, OP_STA=3, OP_JMP=4, OP_JZ=5, OP_OUT=14, OP_HLT=15, each OPW bits wide, giving the opcode encodings.
REQ-003 SHALL have parameter FIXED_RING, default 0, meaning: 1 = every instruction runs T1..T6; 0 = variable-length cycle.
REQ-004 SHALL have port: clock  input  1  sequencer clock; state advances on falling edge.
REQ-005 SHALL have port: reset  input  1  asynchronous, active-low.
REQ-006 SHALL have port: opcode  input  OPW  IR opcode field.
REQ-007 SHALL have port: z_flag  input  1  accumulator-zero flag.
REQ-008 SHALL have port: resume  input  1  leave HALT.
REQ-009 SHALL have ports, all output 1-bit active-high strobes: pc_out, pc_inc, pc_load, mar_load, ram_rd, ram_wr, ir_load, ir_out, a_load, a_out, b_load, alu_sub, alu_out, out_load.
REQ-010 SHALL have port: halted  output  1  high in HALT.
REQ-011 SHALL have port: last_t  output  1  high in the final T-state of an instruction.
REQ-012 SHALL have port: tstate  output  3  state code: T1..T6 = 1..6, HALT = 7.

Function
REQ-013 State register SHALL update on the falling clock edge; all outputs SHALL be combinational from state, opcode and z_flag.
REQ-014 Fetch SHALL be: T1 pc_out+mar_load; T2 pc_inc; T3 ram_rd+ir_load.
REQ-015 opcode SHALL be valid from T3 onward; at end of T3, OP_HLT -> HALT; otherwise -> T4.
REQ-016 LDA SHALL be: T4 ir_out+mar_load; T5 ram_rd+a_load (last).
REQ-017 ADD SHALL be: T4 ir_out+mar_load; T5 ram_rd+b_load; T6 alu_out+a_load (last).
REQ-018 SUB SHALL equal ADD with alu_sub also high in T5 and T6.
REQ-019 STA SHALL be: T4 ir_out+mar_load; T5 a_out+ram_wr (last).
REQ-020 JMP SHALL be: T4 ir_out+pc_load (last).
REQ-021 JZ SHALL be: T4 ir_out+pc_load only if z_flag=1, else no strobes (T4 last in both cases).
REQ-022 OUT SHALL be: T4 a_out+out_load (last).
REQ-023 Undefined opcodes SHALL execute as NOP: T4 with no strobes, last.
REQ-024 Strobes not listed for a state SHALL be 0.
REQ-025 With FIXED_RING=0, the state after a last state SHALL be T1.
REQ-026 With FIXED_RING=1, states after the last state SHALL run to T6 with no strobes; T6->T1; last_t SHALL assert only in T6.
REQ-027 In HALT, all strobes SHALL be 0 and halted=1; resume=1 at a falling edge -> T1; resume=0 -> stay in HALT.
REQ-028 Illegal state codes 0 SHALL recover to T1 on the next falling edge.
REQ-029 ram_wr and ram_rd SHALL never be high together; pc_inc and pc_load SHALL never be high together.

Reset
REQ-030 reset=0 SHALL force state T1 immediately, independent of clock, including mid-instruction and in HALT.
REQ-031 During reset, outputs SHALL be: tstate=1, pc_out=1, mar_load=1, all other strobes 0, halted=0, last_t=0.
REQ-032 After reset deassertion, the first falling edge SHALL move T1->T2.

Verification
REQ-033 ADD with FIXED_RING=0: reset, opcode=1 -> tstate 1,2,3,4,5,6,1; T6 asserts alu_out+a_load+last_t.
REQ-034 LDA with FIXED_RING=0 vs 1: opcode=0 -> 5-state cycle (1..5,1) vs 6-state cycle with T6 strobes all 0.
REQ-035 JZ: opcode=5, z_flag=1 -> pc_load=1 in T4; z_flag=0 -> pc_load=0; next state T1 in both cases.
REQ-036 HLT: opcode=15 -> after T3, tstate=7 and halted=1 for 10 clocks; pulse resume -> tstate=1.
REQ-037 Reset mid-operation: assert reset=0 in T5 of SUB between clock edges -> tstate=1 immediately with pc_out=1, alu_sub=0.
REQ-038 Strobe exclusion: run all opcodes 0..15 -> ram_rd&ram_wr and pc_inc&pc_load never both 1; opcode 7 behaves as NOP.
